conv_mac_engine: RTL and testbench

CONV_MAC_ENGINE -- requirements
Module: conv_mac_engine

---
 rtl/conv_mac_engine.sv | 164 ++++++++++++++++
 tb/tb_conv_mac_engine.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/conv_mac_engine.sv
// conv_mac_engine: multi-lane multiply-accumulate dot product engine with bias
// load, saturating result register and a valid/ready handshake on both sides.
module conv_mac_engine #(
  parameter int unsigned DW    = 8,
  parameter int unsigned K     = 9,
  parameter int unsigned LANES = 3,
  parameter int unsigned OW    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [K*DW-1:0]   data,
  input  logic [K*DW-1:0]   weight,
  input  logic [OW-1:0]     bias,
  input  logic              signed_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OW-1:0]     result,
  output logic              sat,
  output logic              busy
);

  localparam int unsigned ACCW = 2 * DW + $clog2(K) + 2;
  localparam int unsigned PW   = 2 * DW + 2;
  localparam int unsigned N    = (K + LANES - 1) / LANES;
  localparam int unsigned GW   = (N > 1) ? $clog2(N) : 1;
  // Saturation is evaluated at a width that holds both the accumulator and the
  // OW-bit range limits, so the comparisons never truncate either side.
  localparam int unsigned SW   = ((ACCW > OW) ? ACCW : OW) + 1;

  localparam logic signed [SW-1:0] SMAX = {{(SW - OW + 1){1'b0}}, {(OW - 1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {{(SW - OW + 1){1'b1}}, {(OW - 1){1'b0}}};
  localparam logic signed [SW-1:0] UMAX = {{(SW - OW){1'b0}}, {OW{1'b1}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [GW-1:0]           grp_q;
  logic signed [ACCW-1:0]  acc_q;
  logic [K*DW-1:0]         data_q;
  logic [K*DW-1:0]         weight_q;
  logic                    mode_q;

  logic signed [ACCW-1:0]  lane_sum_c;
  logic signed [ACCW-1:0]  acc_next_c;
  logic signed [SW-1:0]    acc_wide_c;
  logic [OW-1:0]           sat_res_c;
  logic                    sat_flag_c;
  logic signed [OW:0]      bias_x_c;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = ACCUM;
      ACCUM:   if (grp_q == GW'(N - 1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-lane operand select and product sum for the current group; lanes past K pick nothing
  always_comb begin
    logic [DW-1:0]         a;
    logic [DW-1:0]         b;
    logic signed [DW:0]    ax;
    logic signed [DW:0]    bx;
    logic signed [PW-1:0]  prod;
    lane_sum_c = '0;
    for (int j = 0; j < int'(LANES); j++) begin
      a = '0;
      b = '0;
      for (int i = 0; i < int'(K); i++) begin
        if ((i % int'(LANES)) == j && grp_q == GW'(i / int'(LANES))) begin
          a = data_q[i*DW +: DW];
          b = weight_q[i*DW +: DW];
        end
      end
      ax = {mode_q & a[DW-1], a};
      bx = {mode_q & b[DW-1], b};
      prod = PW'(ax * bx);
      lane_sum_c = lane_sum_c + ACCW'(prod);
    end
    acc_next_c = acc_q + lane_sum_c;
  end

  // Clip the final accumulator to the OW range selected by the latched mode
  always_comb begin
    acc_wide_c = SW'(acc_next_c);
    sat_res_c  = acc_wide_c[OW-1:0];
    sat_flag_c = 1'b0;
    if (mode_q) begin
      if (acc_wide_c > SMAX) begin
        sat_res_c  = SMAX[OW-1:0];
        sat_flag_c = 1'b1;
      end else if (acc_wide_c < SMIN) begin
        sat_res_c  = SMIN[OW-1:0];
        sat_flag_c = 1'b1;
      end
    end else begin
      if (acc_wide_c < 0) begin
        sat_res_c  = '0;
        sat_flag_c = 1'b1;
      end else if (acc_wide_c > UMAX) begin
        sat_res_c  = UMAX[OW-1:0];
        sat_flag_c = 1'b1;
      end
    end
  end

  // Bias extended by the incoming mode before loading the accumulator
  always_comb begin
    bias_x_c = {signed_mode & bias[OW-1], bias};
  end

  // State register, datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grp_q     <= '0;
      acc_q     <= '0;
      data_q    <= '0;
      weight_q  <= '0;
      mode_q    <= 1'b0;
      result    <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q   <= data;
            weight_q <= weight;
            mode_q   <= signed_mode;
            acc_q    <= ACCW'(bias_x_c);
            grp_q    <= '0;
          end
        end
        ACCUM: begin
          acc_q <= acc_next_c;
          grp_q <= grp_q + GW'(1);
          if (state_d == DONE) begin
            result <= sat_res_c;
            sat    <= sat_flag_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed self-checking bench for conv_mac_engine at default parameters.
module tb_conv_mac_engine;

  localparam int unsigned DW    = 8;
  localparam int unsigned K     = 9;
  localparam int unsigned LANES = 3;
  localparam int unsigned OW    = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [K*DW-1:0]  data;
  logic [K*DW-1:0]  weight;
  logic [OW-1:0]    bias;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OW-1:0]    result;
  logic             sat;
  logic             busy;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  conv_mac_engine #(.DW(DW), .K(K), .LANES(LANES), .OW(OW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .data(data), .weight(weight), .bias(bias), .signed_mode(signed_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .sat(sat), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [K*DW-1:0] fill(input logic [DW-1:0] v);
    logic [K*DW-1:0] r;
    for (int i = 0; i < int'(K); i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [K*DW-1:0] junk();
    return (K*DW)'({$urandom, $urandom, $urandom});
  endfunction

  // Accept one operand set, scramble inputs afterwards, time the result and check it.
  task automatic run_op(input string tag, input logic [K*DW-1:0] d, input logic [K*DW-1:0] w,
                        input logic [OW-1:0] b, input logic m,
                        input logic [OW-1:0] exp_res, input logic exp_sat);
    int lat;
    data = d; weight = w; bias = b; signed_mode = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    data = junk(); weight = junk(); bias = OW'($urandom); signed_mode = ~m;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_inrdy_lo"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd3);
    check({tag, "_result"}, 32'(result), 32'(exp_res));
    check({tag, "_sat"}, 32'(sat), 32'(exp_sat));
    if (out_ready) begin
      @(posedge clk); #1;
      check({tag, "_inrdy_back"}, 32'(in_ready), 32'd1);
      check({tag, "_ovalid_lo"}, 32'(out_valid), 32'd0);
      check({tag, "_hold_idle"}, 32'(result), 32'(exp_res));
    end
  endtask

  initial begin
    logic [K*DW-1:0] seq;
    int              pulse;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    data = '0; weight = '0; bias = '0; signed_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_sat", 32'(sat), 32'd0);
    rst = 1'b0;

    // 9 * 1*1 + 0
    run_op("u_basic", fill(8'd1), fill(8'd1), 16'd0, 1'b0, 16'd9, 1'b0);
    // 9 * 255*255 = 585225 clips to 0xFFFF
    run_op("u_sat", fill(8'd255), fill(8'd255), 16'd0, 1'b0, 16'hFFFF, 1'b1);
    // 2 * (1+..+9) - 10 = 80
    for (int i = 0; i < int'(K); i++) seq[i*DW +: DW] = DW'(i + 1);
    run_op("s_bias", seq, fill(8'd2), 16'hFFF6, 1'b1, 16'd80, 1'b0);
    // 9 * (-128*127) = -146304 clips to -32768
    run_op("s_negsat", fill(8'h80), fill(8'd127), 16'd0, 1'b1, 16'h8000, 1'b1);
    // 9 * (-1*-1) + (-1) = 8
    run_op("s_neg_ops", fill(8'hFF), fill(8'hFF), 16'hFFFF, 1'b1, 16'd8, 1'b0);
    // 9 * 3*4 + 100 = 208
    run_op("u_bias", fill(8'd3), fill(8'd4), 16'd100, 1'b0, 16'd208, 1'b0);
    // 9 * 127*127 = 145161 clips to 32767
    run_op("s_possat", fill(8'd127), fill(8'd127), 16'd0, 1'b1, 16'h7FFF, 1'b1);
    // unsigned bias 0xFFF0 + 9*2 = 65538 clips to 0xFFFF
    run_op("u_bias_sat", fill(8'd1), fill(8'd2), 16'hFFF0, 1'b0, 16'hFFFF, 1'b1);

    // Backpressure: 9 * 2*3 = 54 held while the consumer stalls
    out_ready = 1'b0;
    run_op("bp", fill(8'd2), fill(8'd3), 16'd0, 1'b0, 16'd54, 1'b0);
    for (int c = 0; c < 5; c++) begin
      data = junk(); weight = junk(); in_valid = c[0];
      @(posedge clk); #1;
      check("bp_result_hold", 32'(result), 32'd54);
      check("bp_inrdy_lo", 32'(in_ready), 32'd0);
      check("bp_ovalid_hi", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_inrdy", 32'(in_ready), 32'd1);
    check("bp_release_ovalid", 32'(out_valid), 32'd0);
    // 9 * 1*5 = 45 from fresh operands
    run_op("bp_fresh", fill(8'd1), fill(8'd5), 16'd0, 1'b0, 16'd45, 1'b0);

    // Reset during the second ACCUM cycle discards the operation
    data = fill(8'd4); weight = fill(8'd4); bias = '0; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_inrdy", 32'(in_ready), 32'd1);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    pulse = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) pulse = 1;
      @(posedge clk); #1;
    end
    check("mid_rst_no_pulse", 32'(pulse), 32'd0);

    // Reset wins over a simultaneous accept
    data = fill(8'd1); weight = fill(8'd1); in_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    check("rst_prio_inrdy", 32'(in_ready), 32'd1);
    check("rst_prio_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
